spi_xform_slave: RTL and testbench

SPI_XFORM_SLAVE -- requirements
Module: spi_xform_slave

---
 rtl/spi_xform_slave.sv | 152 +++++++++++++++
 tb/tb_spi_xform_slave.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_xform_slave.sv
// SPI mode-0 slave: receives a WIDTH-bit word, then shifts back a transformed copy.
// sck/ss/mosi are resynchronised into the clk domain before any use.
module spi_xform_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    input  logic [1:0]       mode,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             done,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RX, TX, HOLD} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q, vld_q;
    logic                   armed;
    logic [CW-1:0]          cnt, cnt_n;
    logic [WIDTH-1:0]       rx_sh, rx_sh_n, tx_sh, tx_sh_n;
    logic [WIDTH-1:0]       rx_data_n, rx_word;
    logic                   miso_n, done_n, err_n;
    logic                   sck_rise, sck_fall, ss_s, mosi_s, last;

    assign sck_rise = sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
    assign sck_fall = ~sck_q[SYNC_STAGES-2] & sck_q[SYNC_STAGES-1];
    assign ss_s     = ss_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign last     = (cnt == CW'(WIDTH - 1));
    assign rx_word  = {rx_sh[WIDTH-2:0], mosi_s};

    function automatic logic [WIDTH-1:0] xform(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        case (m)
            2'b00:   return r;
            2'b01:   return v;
            2'b10:   return ~v;
            default: return ~r;
        endcase
    endfunction

    // vld_q marks when the ss chain holds real samples, so a select that is
    // already low at reset release is not mistaken for a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q     <= '0;
            ss_q      <= '1;
            mosi_q    <= '0;
            vld_q     <= '0;
            armed     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            rx_data   <= '0;
            miso      <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sck_q     <= {sck_q[SYNC_STAGES-2:0], sck};
            ss_q      <= {ss_q[SYNC_STAGES-2:0], ss};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
            vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            armed     <= armed | (vld_q[SYNC_STAGES-1] & ss_s);
            state     <= state_n;
            cnt       <= cnt_n;
            rx_sh     <= rx_sh_n;
            tx_sh     <= tx_sh_n;
            rx_data   <= rx_data_n;
            miso      <= miso_n;
            done      <= done_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rx_sh_n   = rx_sh;
        tx_sh_n   = tx_sh;
        rx_data_n = rx_data;
        miso_n    = miso;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                miso_n = 1'b1;
                cnt_n  = '0;
                if (armed && !ss_s) state_n = RX;
            end
            RX: begin
                if (ss_s) begin
                    err_n   = 1'b1;
                    miso_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (sck_rise) begin
                    rx_sh_n = rx_word;
                    if (last) begin
                        rx_data_n = rx_word;
                        tx_sh_n   = xform(rx_word, mode);
                        cnt_n     = '0;
                        state_n   = TX;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            TX: begin
                if (ss_s) begin
                    err_n   = 1'b1;
                    miso_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    if (sck_fall) begin
                        miso_n  = tx_sh[WIDTH-1];
                        tx_sh_n = {tx_sh[WIDTH-2:0], 1'b0};
                    end
                    if (sck_rise) begin
                        if (last) begin
                            done_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = HOLD;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (sck_fall) miso_n = 1'b1;
                if (ss_s) begin
                    miso_n  = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_spi_xform_slave.sv
// Randomised frame bench for spi_xform_slave at WIDTH=8 and WIDTH=16,
// compared against an arithmetic model of the reply transform.
module tb_spi_xform_slave;

    logic        clk = 1'b0;
    logic        reset, sck, ss, mosi;
    logic [1:0]  mode;
    logic        miso8, done8, err8;
    logic        miso16, done16, err16;
    logic [7:0]  rx8;
    logic [15:0] rx16;

    int checks = 0, failures = 0;
    int nd8 = 0, ne8 = 0, nd16 = 0, ne16 = 0, ovl = 0;

    always #5 clk = ~clk;

    spi_xform_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .mosi(mosi),
        .mode(mode), .miso(miso8), .rx_data(rx8), .done(done8),
        .frame_err(err8)
    );

    spi_xform_slave #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .mosi(mosi),
        .mode(mode), .miso(miso16), .rx_data(rx16), .done(done16),
        .frame_err(err16)
    );

    always @(negedge clk) begin
        if (done8)  nd8++;
        if (err8)   ne8++;
        if (done16) nd16++;
        if (err16)  ne16++;
        if ((done8 && err8) || (done16 && err16)) ovl++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_x(input int w, input logic [31:0] v,
                                          input logic [1:0] m);
        logic [31:0] mask, rev;
        mask = (32'd1 << w) - 1;
        rev  = 0;
        for (int i = 0; i < w; i++) rev = (rev << 1) | ((v >> i) & 1);
        case (m)
            2'd0:    return rev;
            2'd1:    return v & mask;
            2'd2:    return ~v & mask;
            default: return ~rev & mask;
        endcase
    endfunction

    function automatic logic miso_w(input int w);
        return (w == 16) ? miso16 : miso8;
    endfunction

    function automatic logic [31:0] rx_w(input int w);
        return (w == 16) ? {16'h0, rx16} : {24'h0, rx8};
    endfunction

    task automatic sel(input logic v);
        @(negedge clk);
        ss = v;
        repeat (8) @(negedge clk);
    endtask

    task automatic sck_cycles(input int w, input int n, input logic [31:0] data,
                              input int hp, output logic [31:0] got);
        got = 0;
        for (int j = 0; j < n; j++) begin
            mosi = (j < w) ? data[w-1-j] : 1'($urandom);
            if (j == w) mode = 2'($urandom);
            repeat (hp) @(negedge clk);
            sck = 1'b1;
            if (j >= w && j < 2 * w) got = {got[30:0], miso_w(w)};
            if (j >= 2 * w) check("hold_miso", {31'h0, miso_w(w)}, 32'h1);
            repeat (hp) @(negedge clk);
            sck = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input int w, input logic [31:0] data,
                         input logic [1:0] md, input int hp, input int extra);
        logic [31:0] got;
        int d0, e0;
        mode = md;
        sel(1'b1);
        d0 = (w == 16) ? nd16 : nd8;
        e0 = (w == 16) ? ne16 : ne8;
        sel(1'b0);
        sck_cycles(w, 2 * w + extra, data, hp, got);
        check("reply", got, ref_x(w, data, md));
        check("rx_data", rx_w(w), data);
        check("done_cnt", ((w == 16) ? nd16 : nd8) - d0, 1);
        check("miso_idle", {31'h0, miso_w(w)}, 32'h1);
        sel(1'b1);
        check("no_err", ((w == 16) ? ne16 : ne8) - e0, 0);
    endtask

    initial begin
        logic [31:0] got, keep;
        int d0, e0, w;
        reset = 1'b1; sck = 1'b0; ss = 1'b1; mosi = 1'b0; mode = 2'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_miso", {31'h0, miso8}, 32'h1);
        check("rst_rx", {24'h0, rx8}, 32'h0);
        check("rst_done", {31'h0, done8}, 32'h0);
        check("rst_err", {31'h0, err8}, 32'h0);

        frame(8, 32'h01, 2'd0, 4, 0);
        frame(8, 32'hA5, 2'd1, 5, 0);
        frame(8, 32'h0F, 2'd2, 4, 0);
        frame(8, 32'h01, 2'd3, 6, 0);

        // abort after five receive bits
        keep = rx_w(8);
        mode = 2'd0;
        sel(1'b1);
        d0 = nd8; e0 = ne8;
        sel(1'b0);
        sck_cycles(8, 5, 32'hC3, 4, got);
        sel(1'b1);
        check("abort_err", ne8 - e0, 1);
        check("abort_done", nd8 - d0, 0);
        check("abort_miso", {31'h0, miso8}, 32'h1);
        check("abort_rx", rx_w(8), keep);
        frame(8, 32'h3C, 2'd0, 4, 0);

        // reset during transmit bit 3, select still low afterwards
        sel(1'b1);
        d0 = nd8; e0 = ne8;
        sel(1'b0);
        sck_cycles(8, 11, 32'h96, 4, got);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_miso", {31'h0, miso8}, 32'h1);
        check("mid_rst_rx", rx_w(8), 32'h0);
        check("mid_rst_done", nd8 - d0, 0);
        check("mid_rst_err", ne8 - e0, 0);
        sck_cycles(8, 16, 32'h5A, 4, got);
        check("rearm_done", nd8 - d0, 0);
        check("rearm_err", ne8 - e0, 0);
        check("rearm_rx", rx_w(8), 32'h0);
        frame(8, 32'h96, 2'd1, 4, 0);

        frame(16, 32'h1234, 2'd0, 4, 4);
        frame(8, 32'hFF, 2'd1, 4, 0);
        frame(8, 32'h00, 2'd1, 4, 0);

        for (int k = 0; k < 16; k++) begin
            w = ($urandom_range(0, 1) == 0) ? 8 : 16;
            frame(w, $urandom & ((32'd1 << w) - 1), 2'($urandom),
                  $urandom_range(4, 7), $urandom_range(0, 2));
        end

        check("done_err_excl", ovl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
